// File: rtl/datapath_seq_if.sv
// datapath_seq_if: instruction handshake plus datapath control word of the sequencer.
interface datapath_seq_if #(parameter int ADDR_W = 3, OP_W = 3, BS_W = 3);
  logic in_valid, in_ready;
  logic [OP_W-1:0] in_op;
  logic [ADDR_W-1:0] in_rd, in_ra, in_rb;
  logic [ADDR_W-1:0] reg_add;
  logic RNW;
  logic [BS_W-1:0] BS;
  logic WrA, WrB;
  logic [OP_W-1:0] ALUop;
  logic busy, done, err;
  modport master (
    input in_valid, in_op, in_rd, in_ra, in_rb,
    output in_ready, reg_add, RNW, BS, WrA, WrB, ALUop, busy, done, err
  );
  modport slave (
    output in_valid, in_op, in_rd, in_ra, in_rb,
    input in_ready, reg_add, RNW, BS, WrA, WrB, ALUop, busy, done, err
  );
endinterface

// File: rtl/datapath_seq.sv
// datapath_seq: sequences one instruction at a time into registered datapath control words.
// Optional DPC_UNARY_SKIP_EN: inc/dec skip the operand-B load states.
module datapath_seq #(parameter int ADDR_W = 3, OP_W = 3, BS_W = 3) (
  input logic clk,
  input logic rst,
  datapath_seq_if.master bus
);
  typedef enum logic [3:0] {IDLE, RDA, MXA, LDA, RDB, MXB, LDB, EXE, MXR, WB, DONE, MXI, WBI, ERR} state_t;
  state_t st_q, st_d;
  logic [OP_W-1:0] op_q, op_d, aluop_q, aluop_d;
  logic [ADDR_W-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d, reg_add_q, reg_add_d;
  logic [BS_W-1:0] bs_q, bs_d, imm;
  logic rnw_q, rnw_d, wra_q, wra_d, wrb_q, wrb_d;
  logic in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic accept, skip_b;
  assign accept = bus.in_valid && st_q == IDLE;
`ifdef DPC_UNARY_SKIP_EN
  assign skip_b = op_q == OP_W'(3) || op_q == OP_W'(4);
`else
  assign skip_b = 1'b0;
`endif
  always_comb begin
    op_d = accept ? bus.in_op : op_q;
    rd_d = accept ? bus.in_rd : rd_q;
    ra_d = accept ? bus.in_ra : ra_q;
    rb_d = accept ? bus.in_rb : rb_q;
    st_d = st_q;
    case (st_q)
      IDLE: if (accept) st_d = bus.in_op == '0 ? MXI : (bus.in_op == OP_W'(7) ? ERR : RDA);
      RDA: st_d = MXA;
      MXA: st_d = LDA;
      LDA: st_d = skip_b ? EXE : RDB;
      RDB: st_d = MXB;
      MXB: st_d = LDB;
      LDB: st_d = EXE;
      EXE: st_d = MXR;
      MXR: st_d = WB;
      WB, WBI: st_d = DONE;
      MXI: st_d = WBI;
      default: st_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_comb begin
    imm = BS_W'(rb_d[1:0]);
    reg_add_d = (st_d inside {RDA, MXA}) ? ra_d : (st_d inside {RDB, MXB}) ? rb_d : (st_d inside {WB, WBI}) ? rd_d : '0;
    rnw_d = !(st_d inside {WB, WBI});
    bs_d = (st_d inside {MXA, LDA, RDB, MXB, LDB}) ? BS_W'(4) : (st_d inside {MXR, WB}) ? BS_W'(5) : (st_d inside {MXI, WBI}) ? imm : '0;
    wra_d = st_d == LDA;
    wrb_d = st_d == LDB;
    aluop_d = (st_d inside {EXE, MXR, WB}) ? op_d : '0;
    in_ready_d = st_d == IDLE;
    busy_d = st_d != IDLE;
    done_d = st_d == DONE;
    err_d = st_d == ERR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      op_q <= '0;
      rd_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      reg_add_q <= '0;
      rnw_q <= 1'b1;
      bs_q <= '0;
      wra_q <= 1'b0;
      wrb_q <= 1'b0;
      aluop_q <= '0;
      in_ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      rd_q <= rd_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      reg_add_q <= reg_add_d;
      rnw_q <= rnw_d;
      bs_q <= bs_d;
      wra_q <= wra_d;
      wrb_q <= wrb_d;
      aluop_q <= aluop_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign bus.in_ready = in_ready_q;
  assign bus.reg_add = reg_add_q;
  assign bus.RNW = rnw_q;
  assign bus.BS = bs_q;
  assign bus.WrA = wra_q;
  assign bus.WrB = wrb_q;
  assign bus.ALUop = aluop_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: random instructions through datapath_seq driving a behavioural datapath, checked against an arithmetic register-file model.
module tb_datapath_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] dp_r [8];
  logic [7:0] exp_r [8];
  logic [7:0] rf_q = '0, dp_a = '0, dp_b = '0, alu_q = '0, exp_b = '0;
  logic [7:0] bus_val;
  logic pre_en = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
`ifdef DPC_UNARY_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [15:0] IDLE_W = {3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'b000};
  always #5 clk = ~clk;
  datapath_seq_if bus ();
  datapath_seq dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a + 8'd1;
      3'd4: return a - 8'd1;
      3'd5: return a & b;
      3'd6: return 8'(a * b);
      default: return 8'd0;
    endcase
  endfunction
  function automatic logic [7:0] konst(input logic [1:0] sel);
    return sel == 2'd3 ? 8'd4 : {6'd0, sel};
  endfunction
  function automatic int lat_of(input logic [2:0] op);
    return op == 3'd0 ? 3 : (SKIP && (op == 3'd3 || op == 3'd4)) ? 7 : 10;
  endfunction
  function automatic logic [15:0] word();
    return {bus.reg_add, bus.RNW, bus.BS, bus.WrA, bus.WrB, bus.ALUop, bus.in_ready, bus.busy, bus.done, bus.err};
  endfunction
  // Responder: register file with registered read, operand buffers, ALU result register, bus mux.
  always_comb
    bus_val = bus.BS == 3'd4 ? rf_q : bus.BS == 3'd5 ? alu_q : bus.BS < 3'd4 ? konst(bus.BS[1:0]) : 8'd0;
  always @(posedge clk) begin
    if (pre_en) dp_r[pre_addr] <= pre_data;
    else if (!bus.RNW) dp_r[bus.reg_add] <= bus_val;
    if (bus.RNW) rf_q <= dp_r[bus.reg_add];
    if (bus.WrA) dp_a <= bus_val;
    if (bus.WrB) dp_b <= bus_val;
    if (bus.ALUop != 3'd0) alu_q <= alu(bus.ALUop, dp_a, dp_b);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask
  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = d;
    exp_r[a] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask
  task automatic ref_exec(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    logic [7:0] a, b;
    a = exp_r[ra];
    b = exp_r[rb];
    if (op == 3'd0) exp_r[rd] = konst(rb[1:0]);
    else if (op != 3'd7) begin
      if (!(SKIP && (op == 3'd3 || op == 3'd4))) exp_b = b;
      exp_r[rd] = alu(op, a, b);
    end
  endtask
  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_rd = rd;
    bus.in_ra = ra;
    bus.in_rb = rb;
  endtask
  task automatic finish_check(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    int lat, wr, errs, rdy, err_n, dn;
    logic [2:0] wa, ra1, bs1;
    logic busy1;
    lat = 0; wr = 0; errs = 0; rdy = 31; err_n = 0; dn = 0;
    wa = '0; ra1 = '0; bs1 = '0; busy1 = 1'b0;
    ref_exec(op, rd, ra, rb);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        busy1 = bus.busy;
        ra1 = bus.reg_add;
        bs1 = bus.BS;
      end
      if (!bus.RNW) begin
        wr++;
        wa = bus.reg_add;
      end
      if (bus.err) errs++;
      if (bus.err && err_n == 0) err_n = n;
      if (bus.done) dn++;
      if (bus.done && lat == 0) lat = n;
      if (bus.in_ready) begin
        rdy = n;
        break;
      end
    end
    chk("busy", 32'(busy1), 32'd1);
    chk("first_reg_add", 32'(ra1), (op == 3'd0 || op == 3'd7) ? 32'd0 : 32'(ra));
    chk("first_bs", 32'(bs1), op == 3'd0 ? 32'(rb[1:0]) : 32'd0);
    chk("done_lat", 32'(lat), op == 3'd7 ? 32'd0 : 32'(lat_of(op)));
    chk("done_count", 32'(dn), op == 3'd7 ? 32'd0 : 32'd1);
    chk("ready_back", 32'(rdy), op == 3'd7 ? 32'd2 : 32'(lat_of(op) + 1));
    chk("writes", 32'(wr), op == 3'd7 ? 32'd0 : 32'd1);
    if (op != 3'd7) chk("write_addr", 32'(wa), 32'(rd));
    chk("err_cycle", 32'(err_n), op == 3'd7 ? 32'd1 : 32'd0);
    chk("err_count", 32'(errs), op == 3'd7 ? 32'd1 : 32'd0);
    chk("rd_value", 32'(dp_r[rd]), 32'(exp_r[rd]));
    chk("buf_b", 32'(dp_b), 32'(exp_b));
  endtask
  task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    drive(op, rd, ra, rb);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.in_op = 3'($urandom);
    bus.in_rd = 3'($urandom);
    bus.in_ra = 3'($urandom);
    bus.in_rb = 3'($urandom);
    finish_check(op, rd, ra, rb);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int w;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_rd = '0;
    bus.in_ra = '0;
    bus.in_rb = '0;
    repeat (3) @(negedge clk);
    chk("reset_word", 32'(word()), 32'(IDLE_W));
    rst = 1'b0;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom));
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("pulse_word", 32'(word()), 32'(IDLE_W));
    #1 rst = 1'b0;
    bus.in_op = 3'($urandom);
    bus.in_rd = 3'($urandom);
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.RNW) w++;
    end
    chk("idle_writes", 32'(w), 32'd0);
    run(3'd0, 3'd5, 3'd1, 3'd3);
    chk("ldi_r5", 32'(dp_r[5]), 32'd4);
    preload(3'd1, 8'd7);
    preload(3'd2, 8'd3);
    run(3'd2, 3'd3, 3'd1, 3'd2);
    chk("sub_r3", 32'(dp_r[3]), 32'd4);
    preload(3'd4, 8'd9);
    run(3'd3, 3'd4, 3'd4, 3'd6);
    chk("inc_r4", 32'(dp_r[4]), 32'd10);
    run(3'd7, 3'd6, 3'd1, 3'd2);
    preload(3'd5, 8'h55);
    @(negedge clk);
    drive(3'd1, 3'd5, 3'd1, 3'd2);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    w = 0;
    while (bus.RNW && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("wb_seen", 32'(w), 32'd9);
    #2 rst = 1'b1;
    #1 chk("rst_rnw", 32'(bus.RNW), 32'd1);
    chk("rst_word", 32'(word()), 32'(IDLE_W));
    @(negedge clk);
    rst = 1'b0;
    exp_b = exp_r[2];
    chk("rst_no_write", 32'(dp_r[5]), 32'h55);
    run(3'd2, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    drive(3'd0, 3'd6, 3'd0, 3'd2);
    @(posedge clk);
    #1 drive(3'd1, 3'd7, 3'd6, 3'd6);
    finish_check(3'd0, 3'd6, 3'd0, 3'd2);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    finish_check(3'd1, 3'd7, 3'd6, 3'd6);
    chk("b2b_r7", 32'(dp_r[7]), 32'd4);
    run(3'd4, 3'd2, 3'd2, 3'd1);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom));
    end
    for (int i = 0; i < 8; i++) chk("final_reg", 32'(dp_r[i]), 32'(exp_r[i]));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
